// File: rtl/if_id_skid_buffer.sv
// Two-entry skid buffer between instruction fetch and decode.
// Each entry carries the instruction, its PC, the predictor bit and an
// immediate-type code pre-decoded at capture time, so decode sees a
// registered type. in_ready is a flop, so fetch never sees a combinational
// path from decode's out_ready. Empty entries hold NOP/reset values so the
// outputs are well defined whenever out_valid is low.
module if_id_skid_buffer #(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC_TAG = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            in_pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic            out_pred_taken,
  output logic [2:0]      out_imm_type,
  output logic            out_illegal
);

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    logic            pred;
    logic [2:0]      imm_type;
    logic            illegal;
  } entry_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam entry_t RESET_ENTRY = '{inst: NOP_INST, pc: RESET_PC_TAG,
                                     pred: 1'b0, imm_type: 3'b000, illegal: 1'b0};

  // Opcode pre-decode: returns {illegal, imm_type}.
  function automatic logic [3:0] predecode(input logic [31:0] inst);
    logic [3:0] r;
    r = {1'b1, 3'b000};
    if (inst[1:0] != 2'b11) begin
      r = {1'b1, 3'b000};
    end else begin
      case (inst[6:0])
        7'b0000011, 7'b0000111, 7'b1100111: r = {1'b0, 3'b001};
        7'b0010011:                         r = {1'b0, 3'b110};
        7'b0110111, 7'b0010111:             r = {1'b0, 3'b010};
        7'b1100011:                         r = {1'b0, 3'b011};
        7'b0100011, 7'b0100111:             r = {1'b0, 3'b100};
        7'b1101111:                         r = {1'b0, 3'b101};
        7'b0110011, 7'b1010011,
        7'b1110011, 7'b0001111:             r = {1'b0, 3'b000};
        default:                            r = {1'b1, 3'b000};
      endcase
    end
    return r;
  endfunction

  entry_t     entry0_q, entry0_d;
  entry_t     entry1_q, entry1_d;
  logic [1:0] count_q, count_d;
  logic       in_ready_q, in_ready_d;

  logic       push_s;
  logic       pop_s;
  logic [3:0] dec_s;
  entry_t     new_entry_s;

  assign out_valid = (count_q != 2'd0);
  assign in_ready  = in_ready_q;
  assign push_s    = in_valid & in_ready_q;
  assign pop_s     = out_valid & out_ready;

  assign out_inst       = entry0_q.inst;
  assign out_pc         = entry0_q.pc;
  assign out_pred_taken = entry0_q.pred;
  assign out_imm_type   = entry0_q.imm_type;
  assign out_illegal    = entry0_q.illegal;

  // Build the incoming entry with its pre-decoded immediate type.
  always_comb begin
    dec_s       = predecode(in_inst);
    new_entry_s = '{inst: in_inst, pc: in_pc, pred: in_pred_taken,
                    imm_type: dec_s[2:0], illegal: dec_s[3]};
  end

  // Next-state for occupancy and entries; flush wins over any handshake.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (flush) begin
      entry0_d = RESET_ENTRY;
      entry1_d = RESET_ENTRY;
      count_d  = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push_s) begin
            entry0_d = new_entry_s;
            count_d  = 2'd1;
          end else begin
            count_d  = 2'd0;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            entry0_d = new_entry_s;
          end else if (push_s) begin
            entry1_d = new_entry_s;
            count_d  = 2'd2;
          end else if (pop_s) begin
            entry0_d = RESET_ENTRY;
            count_d  = 2'd0;
          end else begin
            count_d  = 2'd1;
          end
        end
        2'd2: begin
          // in_ready is low here, so only a pop can occur.
          if (pop_s) begin
            entry0_d = entry1_q;
            entry1_d = RESET_ENTRY;
            count_d  = 2'd1;
          end else begin
            count_d  = 2'd2;
          end
        end
        default: begin
          entry0_d = RESET_ENTRY;
          entry1_d = RESET_ENTRY;
          count_d  = 2'd0;
        end
      endcase
    end
    in_ready_d = (count_d < 2'd2);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q   <= RESET_ENTRY;
      entry1_q   <= RESET_ENTRY;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      entry0_q   <= entry0_d;
      entry1_q   <= entry1_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Scoreboard bench for if_id_skid_buffer: accepted pushes queue their
// hand-computed expected entry, a negedge monitor pops and compares on
// every DUT pop, and directed checks cover reset, back-pressure, flush.
module tb_if_id_skid_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        in_pred_taken;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_pred_taken;
  logic [2:0]  out_imm_type;
  logic        out_illegal;

  logic [2:0]  exp_ty;
  logic        exp_ill;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic [2:0]  ty;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  if_id_skid_buffer #(.PC_W(32), .RESET_PC_TAG(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .in_pred_taken(in_pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pred_taken(out_pred_taken),
    .out_imm_type(out_imm_type), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Record expected entries for accepted pushes; flush/reset drop them.
  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) sb.delete();
      else if (in_valid && in_ready)
        sb.push_back('{inst: in_inst, pc: in_pc, pred: in_pred_taken, ty: exp_ty, ill: exp_ill});
    end
  end

  // Compare every consumed head against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected: got inst %h pc %h with nothing expected", out_inst, out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_inst !== e.inst || out_pc !== e.pc || out_pred_taken !== e.pred ||
            out_imm_type !== e.ty || out_illegal !== e.ill) begin
          n_bad++;
          $display("FAIL pop_data: got %h/%h/%b/%b/%b expected %h/%h/%b/%b/%b",
                   out_inst, out_pc, out_pred_taken, out_imm_type, out_illegal,
                   e.inst, e.pc, e.pred, e.ty, e.ill);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic pred, input logic [2:0] ty, input logic ill);
    in_valid      = v;
    in_inst       = inst;
    in_pc         = pc;
    in_pred_taken = pred;
    exp_ty        = ty;
    exp_ill       = ill;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic chk_empty(input string name);
    chk({name, "_valid"}, {63'd0, out_valid}, 64'd0);
    chk({name, "_ready"}, {63'd0, in_ready}, 64'd1);
    chk({name, "_inst"}, {32'd0, out_inst}, 64'h13);
    chk({name, "_pc"}, {32'd0, out_pc}, 64'h0);
    chk({name, "_fields"}, {59'd0, out_pred_taken, out_imm_type, out_illegal}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    idle();
    #12;
    chk_empty("reset");
    rst_n = 1'b1;
    cyc();

    // Single push of addi with 1-cycle latency.
    out_ready = 1'b1;
    drive(1'b1, 32'h00500093, 32'h100, 1'b0, 3'b110, 1'b0);
    cyc();
    idle();
    chk("t1_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_type", {61'd0, out_imm_type}, 64'd6);
    chk("t1_pc", {32'd0, out_pc}, 64'h100);
    chk("t1_illegal", {63'd0, out_illegal}, 64'd0);
    cyc();
    chk_empty("t1_drain");

    // Back-pressure: fill both entries, hold a third word.
    out_ready = 1'b0;
    drive(1'b1, 32'h00000297, 32'h200, 1'b1, 3'b010, 1'b0);
    cyc();
    drive(1'b1, 32'hFE000EE3, 32'h204, 1'b0, 3'b011, 1'b0);
    cyc();
    drive(1'b1, 32'h00A00113, 32'h208, 1'b0, 3'b110, 1'b0);
    chk("t2_full_ready", {63'd0, in_ready}, 64'd0);
    cyc();
    chk("t2_hold_ready", {63'd0, in_ready}, 64'd0);
    chk("t2_hold_head", {32'd0, out_inst}, 64'h00000297);
    out_ready = 1'b1;
    cyc();
    chk("t2_ready_back", {63'd0, in_ready}, 64'd1);
    chk("t2_head_beq", {32'd0, out_inst}, 64'hFE000EE3);
    cyc();
    idle();
    chk("t2_third_head", {32'd0, out_pc}, 64'h208);
    cyc();
    chk("t2_drained", {63'd0, out_valid}, 64'd0);

    // Steady stream: one in, one out per cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h00000033 | (i << 7), 32'(i * 4), i[0], 3'b000, 1'b0);
      cyc();
      chk("t3_valid", {63'd0, out_valid}, 64'd1);
      chk("t3_pc", {32'd0, out_pc}, 64'(i * 4));
      chk("t3_ready", {63'd0, in_ready}, 64'd1);
    end
    idle();
    cyc();

    // Flush while full with a stalled push attempt.
    out_ready = 1'b0;
    drive(1'b1, 32'h00000013, 32'h300, 1'b0, 3'b110, 1'b0);
    cyc();
    drive(1'b1, 32'h00000013, 32'h304, 1'b0, 3'b110, 1'b0);
    cyc();
    drive(1'b1, 32'h00000013, 32'h308, 1'b0, 3'b110, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    idle();
    chk_empty("t4_flush");
    // Flush with one entry popped and a new push discarded.
    drive(1'b1, 32'h00000297, 32'h400, 1'b0, 3'b010, 1'b0);
    cyc();
    out_ready = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'h0000006F, 32'h404, 1'b1, 3'b101, 1'b0);
    cyc();
    flush = 1'b0;
    idle();
    chk_empty("t4_flush_pop");
    cyc();
    chk("t4_still_empty", {63'd0, out_valid}, 64'd0);

    // Pre-decode spot checks: jal, compressed-space illegal, sw.
    drive(1'b1, 32'h0000006F, 32'h500, 1'b1, 3'b101, 1'b0);
    cyc();
    chk("t5_jal", {59'd0, out_pred_taken, out_imm_type, out_illegal}, {59'd0, 1'b1, 3'b101, 1'b0});
    drive(1'b1, 32'h00000002, 32'h504, 1'b0, 3'b000, 1'b1);
    cyc();
    chk("t5_illegal", {60'd0, out_imm_type, out_illegal}, {60'd0, 3'b000, 1'b1});
    drive(1'b1, 32'h00112023, 32'h508, 1'b0, 3'b100, 1'b0);
    cyc();
    idle();
    chk("t5_sw", {60'd0, out_imm_type, out_illegal}, {60'd0, 3'b100, 1'b0});
    cyc();

    // Asynchronous reset mid-cycle while full.
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'h600, 1'b1, 3'b110, 1'b0);
    cyc();
    drive(1'b1, 32'h00112023, 32'h604, 1'b0, 3'b100, 1'b0);
    cyc();
    idle();
    chk("t6_full", {63'd0, in_ready}, 64'd0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_empty("t6_async");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    chk_empty("t6_after");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_skid_buffer.md
Name: if_id_skid_buffer

Overview:
Two-entry skid buffer between instruction fetch and decode. It captures each fetched instruction with its PC and branch-prediction bit. At capture time it pre-decodes the opcode into the 3-bit immediate-type code that the downstream immediate generator consumes, so decode sees a registered type with no opcode decode in its path. It absorbs one cycle of decode back-pressure without a combinational ready path back to fetch, and supports a pipeline flush on branch mispredict.

Parameters:
PC_W, 32, width of the program counter carried with each instruction
RESET_PC_TAG, 0, value driven on out_pc while empty and after reset

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush; discards all held and incoming entries
in_valid  input  1  fetch presents a valid instruction
in_ready  output  1  buffer can accept this cycle (registered)
in_inst  input  32  fetched instruction word
in_pc  input  PC_W  PC of in_inst
in_pred_taken  input  1  branch predictor taken bit for in_inst
out_valid  output  1  head entry valid
out_ready  input  1  decode consumes head this cycle
out_inst  output  32  head instruction word
out_pc  output  PC_W  head PC
out_pred_taken  output  1  head prediction bit
out_imm_type  output  3  immediate-type code for head
out_illegal  output  1  head opcode is not recognised

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, out_valid=0, in_ready=1
  - out_inst=32'h00000013 (NOP), out_pc=RESET_PC_TAG, out_pred_taken=0, out_imm_type=3'b000, out_illegal=0
- Storage: entry0 = head, entry1 = tail; count is 0..2.
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready
  - out_valid = (count!=0); in_ready is a register equal to (count_next<2)
  - out_* are driven directly from entry0 registers; no combinational path from in_* to out_*.
- Count transitions:
  - count0 + push: data goes to entry0; count=1
  - count1, push only: data goes to entry1; count=2
  - count1, pop only: count=0
  - count1, push & pop: new data goes to entry0; count stays 1
  - count2, pop: entry1 moves to entry0; count=1. Push is impossible here since in_ready=0.
  - No push and no pop: all entries hold.
  - A push with in_valid high while in_ready=0 is ignored; fetch must hold its data.
- Flush:
  - Next cycle count=0, out_valid=0, in_ready=1.
  - A push in the flush cycle is discarded.
  - A pop in the flush cycle still counts as consumed.
  - out_* fields return to their reset values.
- Pre-decode, computed on in_inst at push and stored with the entry (op = inst[6:0]):
  - 0000011 load, 0000111 FP load, 1100111 JALR -> 3'b001 (I-type, 12-bit immediate)
  - 0010011 OP-IMM -> 3'b110 (I-type with shift-amount handling)
  - 0110111 LUI, 0010111 AUIPC -> 3'b010 (U-type)
  - 1100011 branch -> 3'b011 (B-type)
  - 0100011 store, 0100111 FP store -> 3'b100 (S-type)
  - 1101111 JAL -> 3'b101 (J-type)
  - 0110011 OP, 1010011 OP-FP, 1110011 SYSTEM, 0001111 FENCE -> 3'b000
  - Any other op, or inst[1:0]!=2'b11 -> type 3'b000 and illegal=1; illegal=0 for all listed ops.
- Reset asserted mid-operation clears all state immediately; entries are lost.

Test Plan:
- Reset, then single push of inst=32'h00500093 (addi x1,x0,5), pc=0x100, out_ready=1 -> next cycle out_valid=1, out_imm_type=110, out_pc=0x100, illegal=0; following cycle out_valid=0.
- out_ready=0, push 0x00000297 (auipc) then 0xFE000EE3 (beq) -> count=2, in_ready=0 on cycle 3. Third push with in_valid held is ignored. Raise out_ready -> auipc (type 010) then beq (type 011) emitted in order; held third word accepted once in_ready=1.
- Steady stream with out_ready=1 and one push every cycle -> one instruction out per cycle, in_ready stays 1, latency exactly 1 cycle, PCs 0x0,0x4,0x8 in order.
- count=2 plus a simultaneous push attempt, then flush=1 -> next cycle out_valid=0, in_ready=1, out_inst=0x00000013; nothing from before the flush emerges.
- Push 0x0000006F (jal) -> type 101. Push 0x00000002 (inst[1:0]=10) -> type 000, illegal=1. Push 0x00112023 (sw) -> type 100.
- Assert rst_n low asynchronously mid-clock with count=2 -> outputs reset immediately, before the next clock edge.
